// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: sweep FSM states,
// default geometry and the register-index width helper.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // A one-entry file would still need a 1-bit index, so never return zero.
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// One storage word of the register file. The zero input outranks the load
// input so that a clear sweep always wins over a write.
module regfile_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_zero,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_q <= '0;
    else if (i_zero) r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/regfile_p.sv
// DEPTH x WIDTH register file with one write port, two bypassed read ports,
// a per-register written scoreboard and a one-register-per-cycle clear sweep.
module regfile_p
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = idxWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             clear,
  output logic             busy,
  output logic [DEPTH-1:0] written
);

  state_t           r_state;
  state_t           w_nextState;
  logic [AW-1:0]    r_idx;
  logic [DEPTH-1:0] r_written;
  logic             w_writeEn;
  logic             w_sweepEn;
  logic             w_bypassOk;
  logic [WIDTH-1:0] w_regs [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (clear) w_nextState = CLEAR;
      CLEAR:   if (r_idx == AW'(DEPTH - 1)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A simultaneous clear request drops the write, but bypass still shows data_in.
  always_comb begin
    busy       = 1'b0;
    w_sweepEn  = 1'b0;
    w_writeEn  = 1'b0;
    w_bypassOk = 1'b0;
    case (r_state)
      IDLE: begin
        w_writeEn  = write && !clear;
        w_bypassOk = write;
      end
      CLEAR: begin
        busy      = 1'b1;
        w_sweepEn = 1'b1;
      end
      default: ;
    endcase
  end

  // The index wraps to zero on the last sweep edge, ready for the next clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_idx <= '0;
    else if (w_sweepEn) r_idx <= r_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_written <= '0;
    else if (w_sweepEn) r_written[r_idx] <= 1'b0;
    else if (w_writeEn) r_written[writenum] <= 1'b1;
  end

  assign written = r_written;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    regfile_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_writeEn && (writenum == AW'(g))),
      .i_zero (w_sweepEn && (r_idx == AW'(g))),
      .i_d    (data_in),
      .o_q    (w_regs[g])
    );
  end

  assign data_out_a = (w_bypassOk && (writenum == readnum_a)) ? data_in : w_regs[readnum_a];
  assign data_out_b = (w_bypassOk && (writenum == readnum_b)) ? data_in : w_regs[readnum_b];

endmodule

// File: tb/tb_regfile_p.sv
// Self-checking bench for regfile_p: directed vector table, hand-written
// sweep/reset sequences, randomized traffic and a WIDTH=32/DEPTH=16 instance.
module tb_regfile_p;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic [15:0] data_out_a;
  logic [15:0] data_out_b;
  logic        clear;
  logic        busy;
  logic [7:0]  written;

  logic [31:0] vDataIn;
  logic [3:0]  vWritenum;
  logic        vWrite;
  logic [3:0]  vReadA;
  logic [3:0]  vReadB;
  logic [31:0] vOutA;
  logic [31:0] vOutB;
  logic        vClear;
  logic        vBusy;
  logic [15:0] vWritten;

  int testCount = 0;
  int failCount = 0;

  // Reference model: register contents, scoreboard and remaining sweep edges.
  logic [15:0] mReg [8];
  logic [7:0]  mWritten;
  int          sweepLeft;

  typedef struct {
    logic        wr;
    logic [2:0]  wn;
    logic [15:0] d;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        clr;
    logic [15:0] expA;
    logic [15:0] expB;
    logic        expBusy;
    logic [7:0]  expWritten;
  } vec_t;

  vec_t vecs [5];

  regfile_p dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .writenum   (writenum),
    .write      (write),
    .readnum_a  (readnum_a),
    .readnum_b  (readnum_b),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b),
    .clear      (clear),
    .busy       (busy),
    .written    (written)
  );

  regfile_p #(.WIDTH(32), .DEPTH(16)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (vDataIn),
    .writenum   (vWritenum),
    .write      (vWrite),
    .readnum_a  (vReadA),
    .readnum_b  (vReadB),
    .data_out_a (vOutA),
    .data_out_b (vOutB),
    .clear      (vClear),
    .busy       (vBusy),
    .written    (vWritten)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mReg[i] = '0;
    mWritten  = '0;
    sweepLeft = 0;
  endtask

  // Applies what one rising edge does to the model, given the held inputs.
  task automatic modelEdge();
    if (sweepLeft > 0) begin
      mReg[8 - sweepLeft]     = '0;
      mWritten[8 - sweepLeft] = 1'b0;
      sweepLeft--;
    end else if (clear) begin
      sweepLeft = 8;
    end else if (write) begin
      mReg[writenum]     = data_in;
      mWritten[writenum] = 1'b1;
    end
  endtask

  function automatic logic [15:0] modelRead(input logic [2:0] idx);
    if (sweepLeft == 0 && write && writenum == idx) return data_in;
    return mReg[idx];
  endfunction

  task automatic applyStimulus(input logic wr, input logic [2:0] wn, input logic [15:0] d,
                               input logic [2:0] ra, input logic [2:0] rb, input logic clr);
    write     = wr;
    writenum  = wn;
    data_in   = d;
    readnum_a = ra;
    readnum_b = rb;
    clear     = clr;
  endtask

  task automatic checkOutput();
    checkVal("readA", 32'(data_out_a), 32'(modelRead(readnum_a)));
    checkVal("readB", 32'(data_out_b), 32'(modelRead(readnum_b)));
    checkVal("busy", 32'(busy), 32'(sweepLeft > 0));
    checkVal("written", 32'(written), 32'(mWritten));
  endtask

  // Check mid-cycle, take the edge, then resume 1 time unit after it.
  task automatic cycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic fillAll();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 3'(i), 3'((i + 7) % 8), 1'b0);
      cycle();
    end
  endtask

  initial begin
    int count;

    vecs[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 8'h08};
    vecs[2] = '{1'b1, 3'd2, 16'h5555, 3'd2, 3'd0, 1'b0, 16'h5555, 16'h0000, 1'b0, 8'h08};
    vecs[3] = '{1'b1, 3'd5, 16'h1234, 3'd5, 3'd2, 1'b0, 16'h1234, 16'h5555, 1'b0, 8'h0C};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd3, 1'b0, 16'h1234, 16'hBEEF, 1'b0, 8'h2C};

    reset = 1'b1;
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
    vDataIn = '0; vWritenum = '0; vWrite = 1'b0; vReadA = '0; vReadB = '0; vClear = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput();

    // Directed vector table: write, read-back, bypass on one port only.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].wn, vecs[i].d, vecs[i].ra, vecs[i].rb, vecs[i].clr);
      @(negedge clk);
      checkVal($sformatf("vec%0d.A", i), 32'(data_out_a), 32'(vecs[i].expA));
      checkVal($sformatf("vec%0d.B", i), 32'(data_out_b), 32'(vecs[i].expB));
      checkVal($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkVal($sformatf("vec%0d.written", i), 32'(written), 32'(vecs[i].expWritten));
      @(posedge clk);
      modelEdge();
      #1;
    end

    // Full sweep: registers zero one per edge, busy for exactly 8 cycles.
    fillAll();
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
    cycle();
    count = 0;
    while (busy && count < 20) begin
      applyStimulus(1'b1, 3'(count + 1), 16'hF00D, 3'(count), 3'((count + 7) % 8), 1'b0);
      #1;
      checkVal("sweepUnswept", 32'(data_out_a), 32'(16'(16'h1111 * (count + 1))));
      checkVal("sweepSwept", 32'(data_out_b), (count == 0) ? 32'h8888 : 32'h0);
      count++;
      cycle();
    end
    checkVal("busyCycles", count, 8);
    checkVal("writtenAfterSweep", 32'(written), 32'h0);

    // Clear and write together: clear wins, then reset aborts the sweep.
    fillAll();
    applyStimulus(1'b1, 3'd1, 16'hAAAA, 3'd0, 3'd2, 1'b1);
    cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd1, 3'd1, 1'b0);
    #1;
    checkVal("clearWinsR1", 32'(data_out_a), 32'h2222);
    checkVal("clearWinsBusy", 32'(busy), 32'h1);
    checkVal("clearWinsWritten", 32'(written), 32'hFF);
    repeat (3) cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd3, 3'd2, 1'b0);
    #1;
    checkVal("midSweepR3", 32'(data_out_a), 32'h4444);
    checkVal("midSweepR2", 32'(data_out_b), 32'h0);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkVal("asyncResetBusy", 32'(busy), 32'h0);
    checkVal("asyncResetWritten", 32'(written), 32'h0);
    for (int i = 0; i < 8; i++) begin
      readnum_a = 3'(i);
      readnum_b = 3'(7 - i);
      #1;
      checkVal("asyncResetReadA", 32'(data_out_a), 32'h0);
      checkVal("asyncResetReadB", 32'(data_out_b), 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 3'd7, 16'h00FF, 3'd0, 3'd1, 1'b0);
    cycle();
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd7, 3'd7, 1'b0);
    #1;
    checkVal("postResetR7", 32'(data_out_a), 32'h00FF);
    checkVal("postResetWritten", 32'(written), 32'h80);

    // Randomized traffic against the model, with occasional clear requests.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 15) == 0));
      cycle();
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0);
    count = 0;
    while (sweepLeft > 0 && count < 20) begin
      cycle();
      count++;
    end
    checkVal("randomDrain", 32'(sweepLeft), 32'h0);

    // Wider, deeper instance: R15 write/read and a 16-cycle sweep.
    vWrite = 1'b1; vWritenum = 4'd15; vDataIn = 32'hDEADBEEF; vReadA = 4'd0; vReadB = 4'd15;
    @(negedge clk);
    checkVal("wideBypass", vOutB, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    vWrite = 1'b0; vReadA = 4'd15;
    #1;
    checkVal("wideReadR15", vOutA, 32'hDEADBEEF);
    checkVal("wideWritten", 32'(vWritten), 32'h8000);
    vClear = 1'b1;
    @(posedge clk);
    #1;
    vClear = 1'b0;
    count = 0;
    while (vBusy && count < 40) begin
      count++;
      @(posedge clk);
      #1;
    end
    checkVal("wideBusyCycles", count, 16);
    checkVal("wideClearedR15", vOutA, 32'h0);
    checkVal("wideClearedWritten", 32'(vWritten), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
